// File: rtl/keccak_pkg.sv
// Shared state encoding, pad constants and sizing helper for the Keccak
// streaming front-end.
package keccak_pkg;

  typedef enum logic [2:0] {
    ST_ABSORB,
    ST_SEND,
    ST_PADBLK,
    ST_WAIT_HASH,
    ST_SQUEEZE
  } keccak_state_e;

  localparam logic [7:0] KECCAK_PAD_KECCAK = 8'h01;
  localparam logic [7:0] KECCAK_PAD_SHA3   = 8'h06;
  localparam logic [7:0] KECCAK_PAD_FINAL  = 8'h80;

  localparam int KECCAK_STATE_BITS = 1600;

  // Rate left over once the capacity is set to twice the digest length.
  function automatic int keccak_rate_bits(input int out_bits);
    return KECCAK_STATE_BITS - 2 * out_bits;
  endfunction

endpackage

// File: rtl/keccak_stream_ctrl_if.sv
// Message-in, block-out, digest-in and digest-out handshakes of the Keccak
// streaming front-end; master is the controller, slave is its surroundings.
interface keccak_stream_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int RATE_BITS = 1088,
  parameter int OUT_BITS  = 256
);
  localparam int BYTES_W = $clog2(DATA_W / 8) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 in_last;
  logic [BYTES_W-1:0]   in_bytes;

  logic                 blk_valid;
  logic                 blk_ready;
  logic [RATE_BITS-1:0] blk_data;
  logic                 blk_last;

  logic                 hash_valid;
  logic [OUT_BITS-1:0]  hash_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic                 out_last;

  logic                 busy;

  modport master (
    input  in_valid, in_data, in_last, in_bytes,
    output in_ready,
    output blk_valid, blk_data, blk_last,
    input  blk_ready,
    input  hash_valid, hash_data,
    output out_valid, out_data, out_last,
    input  out_ready,
    output busy
  );

  modport slave (
    output in_valid, in_data, in_last, in_bytes,
    input  in_ready,
    input  blk_valid, blk_data, blk_last,
    output blk_ready,
    output hash_valid, hash_data,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/keccak_pad_merge.sv
// Combinational merge of the final message word into the block buffer with
// multi-rate padding (suffix byte after the message, 0x80 in the last byte).
module keccak_pad_merge
  import keccak_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         RATE_BITS  = 1088,
  parameter logic [7:0] PAD_SUFFIX = KECCAK_PAD_KECCAK,
  localparam int        W          = RATE_BITS / DATA_W,
  localparam int        WIDX_W     = (W > 1) ? $clog2(W) : 1,
  localparam int        BYTES_W    = $clog2(DATA_W / 8) + 1
) (
  input  logic [RATE_BITS-1:0] buffer,
  input  logic [WIDX_W-1:0]    widx,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [BYTES_W-1:0]   in_bytes,
  output logic [RATE_BITS-1:0] padded,
  output logic                 pad_fits
);
  localparam int BPW = DATA_W / 8;
  localparam int RB  = RATE_BITS / 8;
  localparam int PW  = $clog2(RB) + 2;

  logic [PW-1:0] pad_pos;

  assign pad_pos  = PW'(widx) * PW'(BPW) + PW'(in_bytes);
  assign pad_fits = (pad_pos < PW'(RB));

  genvar gi;
  generate
    for (gi = 0; gi < RB; gi++) begin : g_byte
      localparam int         WI        = gi / BPW;
      localparam int         BI        = gi % BPW;
      localparam logic [7:0] FINAL_XOR = (gi == RB - 1) ? KECCAK_PAD_FINAL : 8'h00;

      logic [7:0] base;

      // Earlier words keep buffered data, the current word keeps only its
      // valid bytes, everything after is cleared.
      always_comb begin
        base = 8'h00;
        if (WIDX_W'(WI) < widx) begin
          base = buffer[gi*8 +: 8];
        end else if ((WIDX_W'(WI) == widx) && (BYTES_W'(BI) < in_bytes)) begin
          base = in_data[BI*8 +: 8];
        end
      end

      assign padded[gi*8 +: 8] = base
                               ^ ((pad_pos == PW'(gi)) ? PAD_SUFFIX : 8'h00)
                               ^ FINAL_XOR;
    end
  endgenerate

endmodule

// File: rtl/keccak_stream_ctrl.sv
// Streaming Keccak front-end: packs message words into padded rate blocks,
// hands them to the permutation core and serialises the digest back out.
module keccak_stream_ctrl
  import keccak_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         RATE_BITS  = 1088,
  parameter int         OUT_BITS   = 256,
  parameter logic [7:0] PAD_SUFFIX = KECCAK_PAD_KECCAK
) (
  input logic                  clk,
  input logic                  rst,
  keccak_stream_ctrl_if.master bus
);
  localparam int W      = RATE_BITS / DATA_W;
  localparam int OW     = OUT_BITS / DATA_W;
  localparam int WIDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int OIDX_W = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [WIDX_W-1:0]    WIDX_LAST = WIDX_W'(W - 1);
  localparam logic [OIDX_W-1:0]    OIDX_LAST = OIDX_W'(OW - 1);
  localparam logic [RATE_BITS-1:0] PAD_ONLY_BLK =
    {KECCAK_PAD_FINAL, {(RATE_BITS - 16){1'b0}}, PAD_SUFFIX};

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_chk_dw
      $error("keccak_stream_ctrl: DATA_W must be 32 or 64");
    end
    if (RATE_BITS % DATA_W != 0) begin : g_chk_rate
      $error("keccak_stream_ctrl: RATE_BITS must be a multiple of DATA_W");
    end
    if (OUT_BITS % DATA_W != 0) begin : g_chk_out
      $error("keccak_stream_ctrl: OUT_BITS must be a multiple of DATA_W");
    end
    if (OUT_BITS > RATE_BITS) begin : g_chk_out_rate
      $error("keccak_stream_ctrl: OUT_BITS must not exceed RATE_BITS");
    end
  endgenerate

  keccak_state_e        state_reg;
  logic [WIDX_W-1:0]    widx_reg;
  logic [RATE_BITS-1:0] buf_reg;
  logic                 pad_pending_reg;
  logic                 blk_last_reg;
  logic [OUT_BITS-1:0]  hash_reg;
  logic [OIDX_W-1:0]    oidx_reg;

  logic [RATE_BITS-1:0] padded_blk;
  logic                 pad_fits;

  keccak_pad_merge #(
    .DATA_W    (DATA_W),
    .RATE_BITS (RATE_BITS),
    .PAD_SUFFIX(PAD_SUFFIX)
  ) u_pad_merge (
    .buffer  (buf_reg),
    .widx    (widx_reg),
    .in_data (bus.in_data),
    .in_bytes(bus.in_bytes),
    .padded  (padded_blk),
    .pad_fits(pad_fits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_ABSORB;
      widx_reg        <= '0;
      buf_reg         <= '0;
      pad_pending_reg <= 1'b0;
      blk_last_reg    <= 1'b0;
      hash_reg        <= '0;
      oidx_reg        <= '0;
    end else begin
      case (state_reg)
        ST_ABSORB: begin
          if (bus.in_valid) begin
            if (bus.in_last && pad_fits) begin
              buf_reg      <= padded_blk;
              blk_last_reg <= 1'b1;
              state_reg    <= ST_SEND;
            end else begin
              buf_reg[widx_reg*DATA_W +: DATA_W] <= bus.in_data;
              if (widx_reg == WIDX_LAST) begin
                // A full last word leaves no room for padding: it follows in its own block.
                blk_last_reg    <= 1'b0;
                pad_pending_reg <= bus.in_last;
                state_reg       <= ST_SEND;
              end else begin
                widx_reg <= widx_reg + WIDX_W'(1);
              end
            end
          end
        end

        ST_SEND: begin
          if (bus.blk_ready) begin
            buf_reg      <= '0;
            widx_reg     <= '0;
            blk_last_reg <= 1'b0;
            if (pad_pending_reg) begin
              state_reg <= ST_PADBLK;
            end else if (blk_last_reg) begin
              state_reg <= ST_WAIT_HASH;
            end else begin
              state_reg <= ST_ABSORB;
            end
          end
        end

        ST_PADBLK: begin
          buf_reg         <= PAD_ONLY_BLK;
          pad_pending_reg <= 1'b0;
          blk_last_reg    <= 1'b1;
          state_reg       <= ST_SEND;
        end

        ST_WAIT_HASH: begin
          if (bus.hash_valid) begin
            hash_reg  <= bus.hash_data;
            oidx_reg  <= '0;
            state_reg <= ST_SQUEEZE;
          end
        end

        ST_SQUEEZE: begin
          if (bus.out_ready) begin
            if (oidx_reg == OIDX_LAST) begin
              oidx_reg  <= '0;
              state_reg <= ST_ABSORB;
            end else begin
              oidx_reg <= oidx_reg + OIDX_W'(1);
            end
          end
        end

        default: state_reg <= ST_ABSORB;
      endcase
    end
  end

  // Handshake outputs decode registered state only, so ready never depends on blk_ready/out_ready.
  assign bus.in_ready  = (state_reg == ST_ABSORB);
  assign bus.blk_valid = (state_reg == ST_SEND);
  assign bus.blk_data  = buf_reg;
  assign bus.blk_last  = blk_last_reg;
  assign bus.out_valid = (state_reg == ST_SQUEEZE);
  assign bus.out_last  = (state_reg == ST_SQUEEZE) && (oidx_reg == OIDX_LAST);
  assign bus.out_data  = (state_reg == ST_SQUEEZE) ? hash_reg[oidx_reg*DATA_W +: DATA_W] : '0;
  assign bus.busy      = !((state_reg == ST_ABSORB) && (widx_reg == '0));

endmodule

// File: tb/tb_keccak_stream_ctrl.sv
// Bench for keccak_stream_ctrl: a Keccak-suffix and a SHA-3-suffix instance
// share one stimulus stream and are checked against a byte-level padding model.
module tb_keccak_stream_ctrl;
  import keccak_pkg::*;

  localparam int DATA_W    = 32;
  localparam int RATE_BITS = 1088;
  localparam int OUT_BITS  = 256;
  localparam int BPW       = DATA_W / 8;
  localparam int RB        = RATE_BITS / 8;
  localparam int W         = RATE_BITS / DATA_W;
  localparam int OW        = OUT_BITS / DATA_W;
  localparam int LIMIT     = 3000;

  localparam logic [255:0] SHA3_EMPTY =
    256'h4a43f8804b0ad882fa493be44dff80f562d661a05647c15166d71ebff8c6ffa7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keccak_stream_ctrl_if #(.DATA_W(DATA_W), .RATE_BITS(RATE_BITS), .OUT_BITS(OUT_BITS)) bus_k ();
  keccak_stream_ctrl_if #(.DATA_W(DATA_W), .RATE_BITS(RATE_BITS), .OUT_BITS(OUT_BITS)) bus_s ();

  assign bus_s.in_valid   = bus_k.in_valid;
  assign bus_s.in_data    = bus_k.in_data;
  assign bus_s.in_last    = bus_k.in_last;
  assign bus_s.in_bytes   = bus_k.in_bytes;
  assign bus_s.blk_ready  = bus_k.blk_ready;
  assign bus_s.hash_valid = bus_k.hash_valid;
  assign bus_s.hash_data  = bus_k.hash_data;
  assign bus_s.out_ready  = bus_k.out_ready;

  keccak_stream_ctrl #(.DATA_W(DATA_W), .RATE_BITS(RATE_BITS), .OUT_BITS(OUT_BITS),
                       .PAD_SUFFIX(KECCAK_PAD_KECCAK)) dut_k (.clk(clk), .rst(rst), .bus(bus_k));
  keccak_stream_ctrl #(.DATA_W(DATA_W), .RATE_BITS(RATE_BITS), .OUT_BITS(OUT_BITS),
                       .PAD_SUFFIX(KECCAK_PAD_SHA3)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  logic [7:0]           msg_q[$];
  logic [RATE_BITS-1:0] last_blk_k, last_blk_s, empty_blk_s;
  logic [DATA_W-1:0]    first_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [RATE_BITS-1:0] obs,
                         input logic [RATE_BITS-1:0] exp);
    int first;
    first = 0;
    for (int j = RB - 1; j >= 0; j--) if (obs[j*8 +: 8] !== exp[j*8 +: 8]) first = j;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: byte %0d observed %h expected %h", tag, first,
             obs[first*8 +: 8], exp[first*8 +: 8]);
    end
  endtask

  // Reference padding: message || suffix || 0* with 0x80 xored into the last byte
  // of the padded stream, cut into rate-sized blocks.
  function automatic logic [RATE_BITS-1:0] exp_blk(input int b, input logic [7:0] suf);
    logic [RATE_BITS-1:0] r;
    logic [7:0] v;
    int len, total, idx;
    len   = msg_q.size();
    total = (len / RB + 1) * RB;
    for (int j = 0; j < RB; j++) begin
      idx = b * RB + j;
      v   = (idx < len) ? msg_q[idx] : 8'h00;
      if (idx == len)       v = v ^ suf;
      if (idx == total - 1) v = v ^ 8'h80;
      r[j*8 +: 8] = v;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus_k.in_valid   = 1'b0;
    bus_k.in_data    = '0;
    bus_k.in_last    = 1'b0;
    bus_k.in_bytes   = '0;
    bus_k.blk_ready  = 1'b0;
    bus_k.hash_valid = 1'b0;
    bus_k.hash_data  = '0;
    bus_k.out_ready  = 1'b0;
  endtask

  // Streams msg_q through both DUTs, plays the core, and drains the digest.
  task automatic run_msg(input int stall, input bit toggle, input bit sha3_digest);
    int len, nw, nb, wi, bi, oi, cyc, stall_left, hash_wait, idx;
    bit acc_w, acc_b, acc_o, pulsed;
    logic [DATA_W-1:0]   wd;
    logic [OUT_BITS-1:0] digest;
    len = msg_q.size();
    nb  = len / RB + 1;
    nw  = (len == 0) ? 1 : (len + BPW - 1) / BPW;
    wi = 0; bi = 0; oi = 0; cyc = 0; stall_left = stall; hash_wait = -1;
    if (sha3_digest) digest = SHA3_EMPTY;
    else for (int k = 0; k < OW; k++) digest[k*DATA_W +: DATA_W] = $urandom;

    while (oi < OW && cyc < LIMIT) begin
      if (bus_k.in_ready && wi < nw) begin
        for (int k = 0; k < BPW; k++) begin
          idx = wi * BPW + k;
          wd[k*8 +: 8] = (idx < len) ? msg_q[idx] : 8'($urandom);
        end
        bus_k.in_valid = 1'b1;
        bus_k.in_data  = wd;
        bus_k.in_last  = (wi == nw - 1);
        bus_k.in_bytes = (wi == nw - 1) ? 3'(len - wi * BPW) : 3'($urandom_range(0, BPW));
      end else begin
        bus_k.in_valid = 1'b0;
      end

      bus_k.blk_ready = 1'b0;
      if (bus_k.blk_valid) begin
        chk("in_ready_low_in_send", bus_k.in_ready, 1'b0);
        chk_blk("blk_data_keccak", bus_k.blk_data, exp_blk(bi, KECCAK_PAD_KECCAK));
        chk_blk("blk_data_sha3", bus_s.blk_data, exp_blk(bi, KECCAK_PAD_SHA3));
        chk("blk_last_keccak", bus_k.blk_last, (bi == nb - 1));
        chk("blk_last_sha3", bus_s.blk_last, (bi == nb - 1));
        if (bi == nb - 1) begin
          last_blk_k = bus_k.blk_data;
          last_blk_s = bus_s.blk_data;
        end
        if (stall_left > 0) stall_left--;
        else bus_k.blk_ready = 1'b1;
      end

      bus_k.hash_valid = (hash_wait == 0);
      bus_k.hash_data  = (hash_wait == 0) ? digest : '0;

      bus_k.out_ready = toggle ? cyc[0] : 1'b1;
      if (bus_k.out_valid) begin
        chk("in_ready_low_in_squeeze", bus_k.in_ready, 1'b0);
        chk("out_data_keccak", bus_k.out_data, digest[oi*DATA_W +: DATA_W]);
        chk("out_data_sha3", bus_s.out_data, digest[oi*DATA_W +: DATA_W]);
        chk("out_last", bus_k.out_last, (oi == OW - 1));
        if (oi == 0) first_out = bus_k.out_data;
      end

      acc_w  = bus_k.in_valid;
      acc_b  = bus_k.blk_valid && bus_k.blk_ready;
      acc_o  = bus_k.out_valid && bus_k.out_ready;
      pulsed = bus_k.hash_valid;

      @(posedge clk);
      #1;
      cyc++;

      if (acc_w) begin
        chk("blk_valid_latency", bus_k.blk_valid, ((wi % W) == W - 1) || (wi == nw - 1));
        wi++;
      end
      if (hash_wait >= 0) hash_wait--;
      if (acc_b) begin
        if (bi == nb - 1) hash_wait = 2;
        bi++;
        stall_left = stall;
      end
      if (pulsed) chk("out_valid_after_hash", bus_k.out_valid, 1'b1);
      if (acc_o) oi++;
    end

    idle_inputs();
    chk("finished_in_budget", (cyc < LIMIT), 1'b1);
    chk("words_consumed", wi, nw);
    chk("blocks_sent", bi, nb);
    chk("idle_after_digest", bus_k.busy, 1'b0);
    $display("msg len=%0d blocks=%0d stall=%0d toggle=%0d cycles=%0d checks=%0d errors=%0d",
             len, nb, stall, toggle, cyc, checks, errors);
  endtask

  task automatic fill_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus_k.in_ready, 1'b1);
    chk("rst_blk_valid", bus_k.blk_valid, 1'b0);
    chk("rst_blk_last", bus_k.blk_last, 1'b0);
    chk_blk("rst_blk_data", bus_k.blk_data, '0);
    chk("rst_out_valid", bus_k.out_valid, 1'b0);
    chk("rst_out_last", bus_k.out_last, 1'b0);
    chk("rst_out_data", bus_k.out_data, '0);
    chk("rst_busy", bus_k.busy, 1'b0);
    rst = 1'b0;

    msg_q.delete();
    run_msg(0, 1'b0, 1'b1);
    chk("empty_sha3_byte0", last_blk_s[7:0], 8'h06);
    chk("empty_sha3_byte135", last_blk_s[135*8 +: 8], 8'h80);
    chk("empty_keccak_byte0", last_blk_k[7:0], 8'h01);
    chk("empty_digest_word0", first_out, 32'hf8c6ffa7);
    empty_blk_s = last_blk_s;

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 1'b0, 1'b0);
    chk("abc_byte3", last_blk_k[3*8 +: 8], 8'h01);
    chk("abc_byte135", last_blk_k[135*8 +: 8], 8'h80);

    fill_random(RB);
    run_msg(0, 1'b0, 1'b0);
    chk("exact_pad_byte0", last_blk_k[7:0], 8'h01);
    chk("exact_pad_byte135", last_blk_k[135*8 +: 8], 8'h80);

    fill_random(RB - 1);
    run_msg(0, 1'b0, 1'b0);
    chk("final_byte_keccak", last_blk_k[135*8 +: 8], 8'h81);
    chk("final_byte_sha3", last_blk_s[135*8 +: 8], 8'h86);

    fill_random(200);
    run_msg(5, 1'b1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random($urandom_range(0, 300));
      run_msg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Partial message, a stray hash pulse, then reset mid-absorb.
    for (int i = 0; i < 10; i++) begin
      bus_k.in_valid   = 1'b1;
      bus_k.in_data    = $urandom;
      bus_k.in_last    = 1'b0;
      bus_k.in_bytes   = 3'(BPW);
      bus_k.hash_valid = (i == 5);
      bus_k.hash_data  = {8{32'($urandom)}};
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk("stray_hash_ignored", bus_k.out_valid, 1'b0);
    chk("busy_mid_absorb", bus_k.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", bus_k.in_ready, 1'b1);
    chk("midrst_blk_valid", bus_k.blk_valid, 1'b0);
    chk("midrst_out_valid", bus_k.out_valid, 1'b0);
    chk("midrst_busy", bus_k.busy, 1'b0);
    chk_blk("midrst_blk_data", bus_k.blk_data, '0);

    msg_q.delete();
    run_msg(0, 1'b0, 1'b1);
    chk_blk("empty_after_reset", last_blk_s, empty_blk_s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
